// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the hazard control unit.
//   hazard_state_e : sequencer state encoding (RUN, MEM_WAIT, FLUSH)
//   NOP_INSN       : instruction word loaded by a pipeline register flush
//   REG_IDX_W      : architectural register index width
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hazard_state_e;

    localparam logic [31:0] NOP_INSN  = 32'h00000013;
    localparam int          REG_IDX_W = 5;

endpackage

// File: rtl/hazard_control_unit_load_use_detect.sv
// load_use_detect: combinational load-use hazard comparator.
//   Inputs : decoding instruction sources (rs1/rs2 + use flags),
//            EX destination register and EX load flag.
//   Output : load_use, high when the decoding instruction needs the
//            result of the load currently in EX. x0 never hazards.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic                 use_rs1,
    input  logic                 use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    output logic                 load_use
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1  = use_rs1 && (rs1 == ex_rd);
    assign hit_rs2  = use_rs2 && (rs2 == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != '0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline sequencer for the 5-stage core.
//   Handles load-use bubbles, data memory freezes and branch redirect
//   flushes. Outputs are combinational from state and inputs.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   IF_ID_Rs1/Rs2, IF_ID_UseRs1/2  decoding instruction sources
//   ID_EX_Rd, ID_EX_MemRead        EX destination / EX is a load
//   EX_BranchTaken                 EX resolved a taken branch/jump
//   MEM_Req, MEM_Ready             data memory request / completion
//   PC_Write..EX_MEM_Write         pipeline register write enables
//   IF_ID/ID_EX/MEM_WB_Flush       load NOP into that register
//   Mem_Timeout                    one-cycle memory abort pulse
// Optional: define HAZARD_PERF_CNT_EN to add Stall_Count/Flush_Count.
// Debug: the current sequencer state is visible as state_q.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 0,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] IF_ID_Rs1,
    input  logic [REG_IDX_W-1:0] IF_ID_Rs2,
    input  logic                 IF_ID_UseRs1,
    input  logic                 IF_ID_UseRs2,
    input  logic [REG_IDX_W-1:0] ID_EX_Rd,
    input  logic                 ID_EX_MemRead,
    input  logic                 EX_BranchTaken,
    input  logic                 MEM_Req,
    input  logic                 MEM_Ready,
    output logic                 PC_Write,
    output logic                 IF_ID_Write,
    output logic                 ID_EX_Write,
    output logic                 EX_MEM_Write,
    output logic                 IF_ID_Flush,
    output logic                 ID_EX_Flush,
    output logic                 MEM_WB_Flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]          Stall_Count,
    output logic [31:0]          Flush_Count,
`endif
    output logic                 Mem_Timeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hazard_state_e     state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]        flush_cnt_q, flush_cnt_d;
    logic              load_use;
    logic              freeze;

    load_use_detect u_load_use_detect (
        .rs1         (IF_ID_Rs1),
        .rs2         (IF_ID_Rs2),
        .use_rs1     (IF_ID_UseRs1),
        .use_rs2     (IF_ID_UseRs2),
        .ex_rd       (ID_EX_Rd),
        .ex_mem_read (ID_EX_MemRead),
        .load_use    (load_use)
    );

    assign freeze = MEM_Req && !MEM_Ready;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        MEM_WB_Flush = 1'b0;
        Mem_Timeout  = 1'b0;

        unique case (state_q)
            RUN: begin
                if (freeze) begin
                    {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write} = 4'b0000;
                    MEM_WB_Flush = 1'b1;
                    state_d      = MEM_WAIT;
                    wait_cnt_d   = WAIT_W'(1);
                end else if (EX_BranchTaken) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    if (FLUSH_CYCLES > 0) begin
                        state_d     = FLUSH;
                        flush_cnt_d = 4'(FLUSH_CYCLES);
                    end
                end else if (load_use) begin
                    // Hold IF/ID and PC, push a bubble into ID/EX.
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write} = 4'b0000;
                MEM_WB_Flush = 1'b1;
                wait_cnt_d   = wait_cnt_q + WAIT_W'(1);
                if (MEM_Ready) begin
                    // Access completes: MEM/WB captures the result.
                    MEM_WB_Flush = 1'b0;
                    EX_MEM_Write = 1'b1;
                    state_d      = RUN;
                    wait_cnt_d   = '0;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                    Mem_Timeout = 1'b1;
                    state_d     = RUN;
                    wait_cnt_d  = '0;
                end
            end
            FLUSH: begin
                if (freeze) begin
                    // Remaining flush slots are NOPs already, so drop them.
                    {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write} = 4'b0000;
                    MEM_WB_Flush = 1'b1;
                    state_d      = MEM_WAIT;
                    wait_cnt_d   = WAIT_W'(1);
                    flush_cnt_d  = '0;
                end else begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    if (flush_cnt_q <= 4'd1) begin
                        state_d     = RUN;
                        flush_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d     = RUN;
                wait_cnt_d  = '0;
                flush_cnt_d = '0;
            end
        endcase

        // Reset forces the safe pipeline state without waiting for a clock.
        if (!rst_n) begin
            {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write} = 4'b0000;
            {IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush}           = 3'b111;
            Mem_Timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_evt_q, flush_evt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, !PC_Write};
        flush_evt_d = flush_evt_q + {31'd0, IF_ID_Flush};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_evt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_evt_q <= flush_evt_d;
        end
    end

    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_evt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: self-checking bench for hazard_control_unit
// with FLUSH_CYCLES=2 and MEM_TIMEOUT=4. Output vector packing:
// {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
//  IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, Mem_Timeout}.
module tb_hazard_control_unit;

    localparam logic [7:0] O_RUN = 8'b1111_0000;
    localparam logic [7:0] O_FRZ = 8'b0000_0010;
    localparam logic [7:0] O_RDR = 8'b1111_1100;
    localparam logic [7:0] O_LU  = 8'b0011_0100;
    localparam logic [7:0] O_REL = 8'b0001_0000;
    localparam logic [7:0] O_TO  = 8'b0000_0011;
    localparam logic [7:0] O_RST = 8'b0000_1110;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, mem_rd, br, req, rdy;
    logic       pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f, mem_to;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count, flush_count;
`endif

    logic [7:0] exp_q[$];
    int         checks = 0;
    int         failures = 0;

    hazard_control_unit #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IF_ID_Rs1      (rs1),
        .IF_ID_Rs2      (rs2),
        .IF_ID_UseRs1   (use1),
        .IF_ID_UseRs2   (use2),
        .ID_EX_Rd       (rd),
        .ID_EX_MemRead  (mem_rd),
        .EX_BranchTaken (br),
        .MEM_Req        (req),
        .MEM_Ready      (rdy),
        .PC_Write       (pc_w),
        .IF_ID_Write    (ifid_w),
        .ID_EX_Write    (idex_w),
        .EX_MEM_Write   (exmem_w),
        .IF_ID_Flush    (ifid_f),
        .ID_EX_Flush    (idex_f),
        .MEM_WB_Flush   (memwb_f),
`ifdef HAZARD_PERF_CNT_EN
        .Stall_Count    (stall_count),
        .Flush_Count    (flush_count),
`endif
        .Mem_Timeout    (mem_to)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f, mem_to};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; mem_rd = 1'b0;
        br = 1'b0; req = 1'b0; rdy = 1'b0;
    endtask

    // Called at a negedge with inputs already applied: push the expected
    // vector, sample mid-cycle, compare, then advance one full cycle.
    task automatic step(input string tag, input logic [7:0] exp);
        exp_q.push_back(exp);
        #1;
        check(tag, outs(), exp_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] e;
        logic       lu;
        idle();

        // Reset held
        @(negedge clk);
        step("reset_hold", O_RST);
        rst_n = 1'b1;
        step("after_reset", O_RUN);

        // Load-use on rs2
        mem_rd = 1'b1; rd = 5'd5; rs2 = 5'd5; use2 = 1'b1;
        step("lu_rs2", O_LU);
        mem_rd = 1'b0;
        step("lu_done", O_RUN);
        mem_rd = 1'b1; rd = 5'd0; rs2 = 5'd0;
        step("lu_x0", O_RUN);
        rd = 5'd7; rs1 = 5'd7; use1 = 1'b1; use2 = 1'b0;
        step("lu_rs1", O_LU);
        use1 = 1'b0;
        step("lu_unused", O_RUN);
        idle();

        // Memory wait: ready low three cycles, then high
        req = 1'b1;
        step("mw_freeze0", O_FRZ);
        step("mw_wait1", O_FRZ);
        step("mw_wait2", O_FRZ);
        rdy = 1'b1;
        step("mw_release", O_REL);
        idle();
        step("mw_run", O_RUN);

        // Branch with two extra flush cycles; branch in FLUSH is ignored
        br = 1'b1;
        step("br_redirect", O_RDR);
        step("br_flush1", O_RDR);
        br = 1'b0;
        step("br_flush2", O_RDR);
        step("br_run", O_RUN);

        // Priority: freeze beats redirect, redirect serviced afterwards
        br = 1'b1; req = 1'b1;
        step("pri_freeze", O_FRZ);
        step("pri_wait", O_FRZ);
        rdy = 1'b1;
        step("pri_release", O_REL);
        req = 1'b0; rdy = 1'b0;
        step("pri_redirect", O_RDR);
        br = 1'b0;
        step("pri_flush1", O_RDR);
        step("pri_flush2", O_RDR);
        step("pri_run", O_RUN);

        // Timeout after four MEM_WAIT cycles
        req = 1'b1;
        step("to_freeze", O_FRZ);
        step("to_wait1", O_FRZ);
        step("to_wait2", O_FRZ);
        step("to_wait3", O_FRZ);
        step("to_pulse", O_TO);
        req = 1'b0;
        step("to_run", O_RUN);

        // Freeze inside FLUSH discards the remaining flush count
        br = 1'b1;
        step("ff_redirect", O_RDR);
        br = 1'b0; req = 1'b1;
        step("ff_freeze", O_FRZ);
        step("ff_wait", O_FRZ);
        rdy = 1'b1;
        step("ff_release", O_REL);
        idle();
        step("ff_run", O_RUN);

        // Async reset mid-FLUSH
        br = 1'b1;
        step("ar_redirect", O_RDR);
        br = 1'b0;
        #1;
        check("ar_in_flush", outs(), O_RDR);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_async", outs(), O_RST);
        @(negedge clk);
        rst_n = 1'b1;
        step("ar_release", O_RUN);

        // Random load-use patterns checked against the hazard equation
        for (int i = 0; i < 24; i++) begin
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            use1   = 1'($urandom_range(0, 1));
            use2   = 1'($urandom_range(0, 1));
            mem_rd = 1'($urandom_range(0, 1));
            lu = mem_rd && (rd != 5'd0) &&
                 ((use1 && rs1 == rd) || (use2 && rs2 == rd));
            e = lu ? O_LU : O_RUN;
            step("rand_lu", e);
        end
        idle();
        step("final_run", O_RUN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 5-stage RISC-V core; companion to the operand forwarding logic.
- Resolves the hazards that forwarding cannot cover:
  - load-use: inserts a bubble;
  - multi-cycle data memory access: freezes the pipeline;
  - taken branch/jump: flushes the pipeline with a configurable redirect penalty.
- Drives write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- FLUSH_CYCLES, 0, extra IF/ID flush cycles after a redirect (instruction memory latency); 0..15
- MEM_TIMEOUT, 64, max MEM_WAIT cycles before abort; must be ≥2

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- IF_ID_Rs1, IF_ID_Rs2  in  5 each  source registers of decoding instruction
- IF_ID_UseRs1, IF_ID_UseRs2  in  1 each  instruction actually reads that source
- ID_EX_Rd  in  5  destination register in EX
- ID_EX_MemRead  in  1  EX instruction is a load
- EX_BranchTaken  in  1  EX resolved taken branch/jump
- MEM_Req  in  1  MEM stage issues a data memory access
- MEM_Ready  in  1  data memory completes this cycle
- PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1 each  register enables
- IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  out  1 each  load NOP into that register
- Mem_Timeout  out  1  one-cycle abort pulse

Behaviour:
- State register, encoding from package: RUN, MEM_WAIT, FLUSH.
- Outputs are combinational from state and inputs. The state and counters are registered.
- Reset (rst_n=0, async), held while low:
  - state=RUN, counters=0;
  - all *_Write=0, all *_Flush=1, Mem_Timeout=0.
  - Reset mid-operation aborts any wait or flush immediately.
- Output priority in RUN: freeze > redirect > load-use.
- Freeze, RUN with MEM_Req=1 and MEM_Ready=0:
  - all *_Write=0, MEM_WB_Flush=1.
  - Next state MEM_WAIT; wait counter loaded with 1.
- Redirect, RUN with EX_BranchTaken=1 and not freezing:
  - PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1, other writes=1.
  - If FLUSH_CYCLES>0: next state FLUSH, flush counter=FLUSH_CYCLES. Otherwise stay in RUN.
- Load-use, RUN with no freeze and no redirect:
  - Condition: ID_EX_MemRead and ID_EX_Rd≠0 and ((IF_ID_UseRs1 and Rs1==Rd) or (IF_ID_UseRs2 and Rs2==Rd)).
  - Response: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, EX_MEM_Write=1. Lasts 1 cycle only; no state change.
- Normal RUN: all *_Write=1, all *_Flush=0.
- MEM_WAIT:
  - Outputs as freeze; the counter increments each cycle.
  - MEM_Ready=1: MEM_WB_Flush=0, EX_MEM_Write=1 and MEM/WB captures. Next state RUN.
  - Counter reaches MEM_TIMEOUT without MEM_Ready: Mem_Timeout=1 for that cycle, MEM_WB_Flush=1. Next state RUN; the trap is handled upstream.
  - A branch in EX during the wait stays held (EX frozen) and is serviced in the first RUN cycle afterwards.
- FLUSH:
  - IF_ID_Flush=1, PC_Write=1, other writes=1, ID_EX_Flush=1.
  - Counter decrements; leave to RUN in the cycle the counter reaches 1.
  - MEM_Req with MEM_Ready=0 in FLUSH: freeze takes precedence, go to MEM_WAIT, and the remaining flush count is discarded. Safe because flushed slots are NOPs.
  - EX_BranchTaken in FLUSH is ignored; EX holds a flushed NOP by construction.
- Rd==x0 never creates a load-use stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds ports Stall_Count and Flush_Count (out, 32 each).
  - Stall_Count counts cycles with PC_Write=0.
  - Flush_Count counts cycles with IF_ID_Flush=1 and rst_n=1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: no ports, no counters; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - state enum (RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2);
  - NOP encoding constant 32'h00000013;
  - register-index width constant 5.
- Sub-module load_use_detect (combinational comparator producing the load-use condition) is instantiated once.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs2=5, IF_ID_UseRs2=1 → exactly 1 cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. With Rd=0 → no stall.
- Memory wait: MEM_Req=1, MEM_Ready low 3 cycles then high → 3 cycles of all writes=0 and MEM_WB_Flush=1; cycle 4 EX_MEM_Write=1 and MEM_WB_Flush=0; then RUN.
- Branch, FLUSH_CYCLES=2: EX_BranchTaken pulse → IF_ID_Flush=1 for 3 consecutive cycles and ID_EX_Flush=1 in all 3; PC_Write=1 throughout.
- Priority: EX_BranchTaken=1 with MEM_Req=1, MEM_Ready=0 → freeze with no flush; on MEM_Ready the next RUN cycle performs the redirect.
- Timeout, MEM_TIMEOUT=4: MEM_Ready never asserted → Mem_Timeout pulses once, 4 cycles after entering MEM_WAIT; state returns to RUN.
- Async reset mid-FLUSH: drop rst_n between clock edges → outputs switch immediately to reset values; after release, the first cycle shows all writes=1 and no flush.
